// File: rtl/if_fetch_unit_pkg.sv
// Shared IF-stage definitions: instruction field map, fetch FSM encoding, field splitter.
// Latency: none (types, constants and a pure function).
// Backpressure: n/a.
package if_fetch_unit_pkg;

  localparam int INSTR_W = 16;

  // Field bit positions, shared by IF/ID and decode
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm_off;
  } instr_fields_t;

  // imm_off deliberately overlaps rs1/rs2; decode picks whichever the opcode needs.
  function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] w);
    instr_fields_t f;
    f.opcode  = w[OPC_MSB:OPC_LSB];
    f.rd      = w[RD_MSB:RD_LSB];
    f.rs1     = w[RS1_MSB:RS1_LSB];
    f.rs2     = w[RS2_MSB:RS2_LSB];
    f.imm_off = w[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read channel: req/addr from fetch, ack/rdata from memory.
// Latency: n/a (wires only).
// Backpressure: req is held with a stable addr until a single-cycle ack.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int PC_W = 16
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: PC, one-outstanding imem read, instruction buffer split into fields.
// Latency: ack -> if_valid_o one cycle; zero-wait memory sustains one instruction per cycle.
// Backpressure: stall_i holds the presented instruction and drops imem_req; redirect overrides stall.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_unit_if.master  imem,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  output logic             if_valid_o,
  output logic [PC_W-1:0]  if_pc_o,
  output logic [3:0]       if_opcode_o,
  output logic [3:0]       if_rd_o,
  output logic [3:0]       if_rs1_o,
  output logic [3:0]       if_rs2_o,
  output logic [7:0]       if_imm_off_o
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    stale_q, stale_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               req;
  logic               ack;
  instr_fields_t      fields;

  // Request is combinational so a stall release re-requests in the same cycle;
  // DRAIN must keep the abandoned request up until memory answers it.
  always_comb begin
    if (rst) begin
      req = 1'b0;
    end else if (state_q == FS_DRAIN) begin
      req = 1'b1;
    end else begin
      req = !valid_q || !stall_i;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = (state_q == FS_DRAIN) ? stale_q : pc_q;
  // An ack with no request outstanding is ignored.
  assign ack            = req && imem.imem_ack;

  // Next-state: redirect first, then drain completion, then normal fetch/consume.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    if_pc_d = if_pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      if (state_q == FS_RUN && req && !ack) begin
        state_d = FS_DRAIN;
        stale_d = pc_q;
      end else if (state_q == FS_DRAIN && ack) begin
        state_d = FS_RUN;
      end
    end else if (state_q == FS_DRAIN) begin
      if (ack) begin
        state_d = FS_RUN;
      end
    end else if (ack) begin
      instr_d = imem.imem_rdata;
      if_pc_d = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + PC_W'(1);
    end else if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end
  end

  // All fetch state; reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
      stale_q <= '0;
      if_pc_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      if_pc_q <= if_pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign fields       = split_instr(instr_q);
  assign if_valid_o   = valid_q;
  assign if_pc_o      = if_pc_q;
  assign if_opcode_o  = fields.opcode;
  assign if_rd_o      = fields.rd;
  assign if_rs1_o     = fields.rs1;
  assign if_rs2_o     = fields.rs2;
  assign if_imm_off_o = fields.imm_off;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with programmable wait, scoreboard of fetched words.
// Latency: expected word pushed on the ack edge, compared while presented, popped when consumed.
// Backpressure: stall/redirect driven per cycle from the stimulus sequence.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int          PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [3:0]  if_opcode, if_rd, if_rs1, if_rs2;
  logic [7:0]  if_imm_off;

  if_fetch_unit_if #(.PC_W(PC_W)) imem_bus ();

  if_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem             (imem_bus),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_opcode_o      (if_opcode),
    .if_rd_o          (if_rd),
    .if_rs1_o         (if_rs1),
    .if_rs2_o         (if_rs2),
    .if_imm_off_o     (if_imm_off)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pc = RESET_PC;
  logic [15:0] stale_exp = '0;
  bit          drain_exp = 1'b0;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  bit          stray_ack = 1'b0;
  bit          prev_pending = 1'b0;
  logic [15:0] prev_addr = '0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] m;
    if (a == 16'h0000) return 16'h1234;
    m = a * 16'h9E37;
    return m ^ 16'h5A5A;
  endfunction

  function automatic logic [47:0] pres(input logic [15:0] pc, input logic [15:0] w);
    return {8'h00, pc, w[15:12], w[11:8], w[7:4], w[3:0], w[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the presented state, answer memory, advance the model.
  task automatic cycle(input bit st, input bit rv, input logic [15:0] rpc);
    bit          a;
    bit          q_has;
    bit          req_exp;
    logic [15:0] addr;
    @(negedge clk);
    stall = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    #1;
    q_has = (sb_q.size() != 0);
    req_exp = !(q_has && st);
    addr = imem_bus.imem_addr;
    chk("if_valid", 48'(if_valid), 48'(q_has));
    if (q_has)
      chk("present", {8'h00, if_pc, if_opcode, if_rd, if_rs1, if_rs2, if_imm_off},
          pres(sb_q[0].pc, sb_q[0].instr));
    chk("imem_req", 48'(imem_bus.imem_req), 48'(req_exp));
    if (imem_bus.imem_req) begin
      chk("imem_addr", 48'(addr), 48'(drain_exp ? stale_exp : exp_pc));
      if (prev_pending) chk("addr_hold", 48'(addr), 48'(prev_addr));
    end
    a = 1'b0;
    if (imem_bus.imem_req) begin
      if (wait_cnt >= mem_lat) begin
        a = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (stray_ack) begin
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 16'hDEAD;
      end
    end
    if (a) begin
      imem_bus.imem_ack = 1'b1;
      imem_bus.imem_rdata = mem_word(addr);
    end
    prev_pending = imem_bus.imem_req && !a && !rv;
    prev_addr = addr;
    // Consumed (no stall) or flushed (redirect) at this edge.
    if (q_has && (!st || rv)) void'(sb_q.pop_front());
    if (rv) begin
      if (!drain_exp && req_exp && !a) begin
        drain_exp = 1'b1;
        stale_exp = exp_pc;
      end else if (drain_exp && a) begin
        drain_exp = 1'b0;
      end
      exp_pc = rpc;
    end else if (a) begin
      if (drain_exp) begin
        drain_exp = 1'b0;
      end else begin
        sb_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        exp_pc = exp_pc + 16'd1;
      end
    end
    @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    #1;
    chk("rst_valid", 48'(if_valid), 48'd0);
    chk("rst_req", 48'(imem_bus.imem_req), 48'd0);
    chk("rst_fields", 48'({if_pc, if_opcode, if_rd, if_rs1, if_rs2, if_imm_off}), 48'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_req", 48'(imem_bus.imem_req), 48'd0);
    rst = 1'b0;
    sb_q.delete();
    exp_pc = RESET_PC;
    drain_exp = 1'b0;
    wait_cnt = 0;
    prev_pending = 1'b0;
  endtask

  initial begin
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    apply_reset();

    // Zero-wait streaming from reset; first word 16'h1234 at address 0
    mem_lat = 0;
    repeat (6) cycle(1'b0, 1'b0, 16'h0);

    // Three wait cycles per fetch
    mem_lat = 3;
    repeat (12) cycle(1'b0, 1'b0, 16'h0);

    // Four-cycle stall with a stray ack that must be ignored
    mem_lat = 0;
    repeat (2) cycle(1'b0, 1'b0, 16'h0);
    stray_ack = 1'b1;
    repeat (4) cycle(1'b1, 1'b0, 16'h0);
    stray_ack = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 16'h0);

    // Redirect while a request is pending -> drain the stale read
    mem_lat = 3;
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0040);
    repeat (8) cycle(1'b0, 1'b0, 16'h0);

    // Redirect coinciding with ack; then redirect during stall
    mem_lat = 0;
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0100);
    repeat (3) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0200);
    repeat (3) cycle(1'b0, 1'b0, 16'h0);

    // Second redirect while draining, acked in the same cycle
    mem_lat = 2;
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0300);
    cycle(1'b0, 1'b1, 16'h0380);
    repeat (6) cycle(1'b0, 1'b0, 16'h0);

    // PC wrap FFFF -> 0000
    mem_lat = 0;
    cycle(1'b0, 1'b1, 16'hFFFE);
    repeat (5) cycle(1'b0, 1'b0, 16'h0);

    // Reset mid-request, then restart from RESET_PC
    mem_lat = 5;
    repeat (2) cycle(1'b0, 1'b0, 16'h0);
    apply_reset();
    mem_lat = 0;
    repeat (4) cycle(1'b0, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
